alu_issue_stage: RTL and testbench

- Decode/issue stage that drives the ALU's control and operand interface. It is the producer side of ALU_Control, operand_A, operand_B and branch_op.
- Accepts one RV32I instruction per cycle from fetch, plus register-file read data, over a valid/ready handshake.
- Decodes it into the ALU_Control encoding and selects operands. Registers everything into the ID/EX pipeline register with downstream valid/ready.
- Handles flush, and holds in a trap state after issuing an illegal instruction.

---
 rtl/rv_decode_pkg.sv | 67 ++++++
 rtl/rv_imm_gen.sv | 17 +
 rtl/alu_issue_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode constants, ALU_Control field layout and the ID/EX payload type.
package rv_decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CLS_ARITH  = 2'b00;
    localparam logic [1:0] CLS_SUBSRA = 2'b01;
    localparam logic [1:0] CLS_BRANCH = 2'b10;
    localparam logic [1:0] CLS_JUMP   = 2'b11;

    localparam int CTRL_RSVD_BIT = 5;
    localparam int CTRL_CLS_HI   = 4;
    localparam int CTRL_CLS_LO   = 3;
    localparam int CTRL_F3_HI    = 2;
    localparam int CTRL_F3_LO    = 0;

    typedef enum logic {ST_RUN, ST_TRAP} state_e;

    typedef struct packed {
        logic [5:0]  alu_ctrl;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] branch_target;
        logic [31:0] link_addr;
        logic [31:0] store_data;
        logic [4:0]  rd_addr;
        logic        rd_write;
        logic        branch_op;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } issue_t;

    function automatic logic [5:0] make_ctrl(input logic [1:0] cls, input logic [2:0] f3);
        logic [5:0] ctrl;
        ctrl = '0;
        ctrl[CTRL_RSVD_BIT]             = 1'b0;
        ctrl[CTRL_CLS_HI:CTRL_CLS_LO]   = cls;
        ctrl[CTRL_F3_HI:CTRL_F3_LO]     = f3;
        return ctrl;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate extraction; only instruction bits [31:7] carry immediates.
module rv_imm_gen (
    input  logic [31:7] instr_hi,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    assign imm_i = {{20{instr_hi[31]}}, instr_hi[31:20]};
    assign imm_s = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
    assign imm_b = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7], instr_hi[30:25], instr_hi[11:8], 1'b0};
    assign imm_u = {instr_hi[31:12], 12'b0};
    assign imm_j = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction per cycle into the ALU control/operand
// interface and registers it into the ID/EX register, with flush and an illegal-op trap state.
module alu_issue_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    input  logic            trap_clear,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      ALU_Control,
    output logic [XLEN-1:0] operand_A,
    output logic [XLEN-1:0] operand_B,
    output logic            branch_op,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] link_addr,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_addr,
    output logic            rd_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            illegal,
    output logic            trap_pending
);

    state_e      state_q, state_d;
    issue_t      dec, out_d, out_q;
    logic        out_valid_q, out_valid_d;
    logic        accept;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    rv_imm_gen u_imm_gen (
        .instr_hi (in_instr[31:7]),
        .imm_i    (imm_i),
        .imm_s    (imm_s),
        .imm_b    (imm_b),
        .imm_u    (imm_u),
        .imm_j    (imm_j)
    );

    always_comb begin
        dec               = '0;
        dec.branch_target = in_pc + imm_b;
        dec.link_addr     = in_pc + 32'd4;
        dec.store_data    = rs2_data;
        dec.rd_addr       = in_instr[11:7];
        unique case (opcode)
            OPC_OP: begin
                dec.alu_ctrl = make_ctrl((in_instr[30] && (funct3 == F3_ADD || funct3 == F3_SR))
                                         ? CLS_SUBSRA : CLS_ARITH, funct3);
                dec.op_a     = rs1_data;
                dec.op_b     = rs2_data;
                dec.rd_write = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_ctrl = make_ctrl((in_instr[30] && funct3 == F3_SR) ? CLS_SUBSRA : CLS_ARITH, funct3);
                dec.op_a     = rs1_data;
                // Shifts take the 5-bit shamt; the funct7 bits above it are not immediate.
                dec.op_b     = (funct3 == F3_SLL || funct3 == F3_SR) ? {27'b0, in_instr[24:20]} : imm_i;
                dec.rd_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_ctrl = make_ctrl(CLS_ARITH, F3_ADD);
                dec.op_a     = rs1_data;
                dec.op_b     = imm_i;
                dec.mem_read = 1'b1;
                dec.rd_write = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_ctrl  = make_ctrl(CLS_ARITH, F3_ADD);
                dec.op_a      = rs1_data;
                dec.op_b      = imm_s;
                dec.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_ctrl  = make_ctrl(CLS_BRANCH, funct3);
                dec.op_a      = rs1_data;
                dec.op_b      = rs2_data;
                dec.branch_op = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_ctrl = make_ctrl(CLS_ARITH, F3_ADD);
                dec.op_b     = imm_u;
                dec.rd_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_ctrl = make_ctrl(CLS_ARITH, F3_ADD);
                dec.op_a     = in_pc;
                dec.op_b     = imm_u;
                dec.rd_write = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_ctrl = make_ctrl(CLS_JUMP, F3_ADD);
                dec.op_a     = in_pc + imm_j;
                dec.rd_write = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_ctrl = make_ctrl(CLS_JUMP, F3_ADD);
                dec.op_a     = rs1_data + imm_i;
                dec.rd_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.rd_addr == 5'd0) dec.rd_write = 1'b0;
    end

    always_comb begin
        in_ready     = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        trap_pending = (state_q == ST_TRAP);
    end

    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (accept && dec.illegal && TRAP_ON_ILLEGAL) state_d = ST_TRAP;
            ST_TRAP: if (trap_clear || flush) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    // Flush beats both a new accept and a held op; otherwise the register holds under stall.
    always_comb begin
        out_valid_d = flush ? 1'b0 : (accept || (out_valid_q && !out_ready));
        out_d       = accept ? dec : out_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign ALU_Control   = out_q.alu_ctrl;
    assign operand_A     = out_q.op_a;
    assign operand_B     = out_q.op_b;
    assign branch_op     = out_q.branch_op;
    assign branch_target = out_q.branch_target;
    assign link_addr     = out_q.link_addr;
    assign store_data    = out_q.store_data;
    assign rd_addr       = out_q.rd_addr;
    assign rd_write      = out_q.rd_write;
    assign mem_read      = out_q.mem_read;
    assign mem_write     = out_q.mem_write;
    assign illegal       = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with hand-computed expected issue bundles.
module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        trap_clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A, operand_B, branch_target, link_addr, store_data;
    logic        branch_op, rd_write, mem_read, mem_write, illegal, trap_pending;
    logic [4:0]  rd_addr;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rdw;
        logic        brop;
        logic        mr;
        logic        mw;
        logic        ill;
        logic [31:0] link;
        logic [31:0] store;
        logic [31:0] target;
        logic        chkTgt;
    } expect_t;

    expect_t scoreboard[$];

    alu_issue_stage dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .trap_clear    (trap_clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_Control   (ALU_Control),
        .operand_A     (operand_A),
        .operand_B     (operand_B),
        .branch_op     (branch_op),
        .branch_target (branch_target),
        .link_addr     (link_addr),
        .store_data    (store_data),
        .rd_addr       (rd_addr),
        .rd_write      (rd_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .illegal       (illegal),
        .trap_pending  (trap_pending)
    );

    always #5 clock = ~clock;

    function automatic expect_t mkExp(input logic [5:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] rd, input logic rdw, input logic brop,
                                      input logic mr, input logic mw, input logic ill,
                                      input logic [31:0] link, input logic [31:0] store,
                                      input logic [31:0] target, input logic chkTgt);
        expect_t e;
        e.ctrl = ctrl; e.a = a; e.b = b; e.rd = rd; e.rdw = rdw; e.brop = brop;
        e.mr = mr; e.mw = mw; e.ill = ill; e.link = link; e.store = store;
        e.target = target; e.chkTgt = chkTgt;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer an instruction (called just after a rising edge) and wait for it to be taken.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                                 input logic [31:0] r2, input expect_t e, input bit push);
        bit taken;
        taken    = 1'b0;
        in_instr = instr;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clock);
            if (in_ready && !flush) begin
                if (push) scoreboard.push_back(e);
                taken = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!taken) checkOutput("accept timeout", 32'(taken), 32'd1);
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected issue", 32'(out_valid), 32'd0);
            end else begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput("ALU_Control", 32'(ALU_Control), 32'(e.ctrl));
                checkOutput("operand_A", operand_A, e.a);
                checkOutput("operand_B", operand_B, e.b);
                checkOutput("rd_addr", 32'(rd_addr), 32'(e.rd));
                checkOutput("rd_write", 32'(rd_write), 32'(e.rdw));
                checkOutput("branch_op", 32'(branch_op), 32'(e.brop));
                checkOutput("mem_read", 32'(mem_read), 32'(e.mr));
                checkOutput("mem_write", 32'(mem_write), 32'(e.mw));
                checkOutput("illegal", 32'(illegal), 32'(e.ill));
                checkOutput("link_addr", link_addr, e.link);
                checkOutput("store_data", store_data, e.store);
                if (e.chkTgt) checkOutput("branch_target", branch_target, e.target);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #12;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset trap_pending", 32'(trap_pending), 32'd0);
        checkOutput("reset ALU_Control", 32'(ALU_Control), 32'd0);
        checkOutput("reset rd_write", 32'(rd_write), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // ADDI x1,x0,5 / SUB x3,x1,x2 / BEQ x1,x2,+8
        applyStimulus(32'h00500093, 32'h0, 32'd0, 32'd0,
                      mkExp(6'h00, 32'd0, 32'd5, 5'd1, 1, 0, 0, 0, 0, 32'h4, 32'd0, 32'h0, 0), 1);
        applyStimulus(32'h402081B3, 32'h4, 32'd7, 32'd3,
                      mkExp(6'h08, 32'd7, 32'd3, 5'd3, 1, 0, 0, 0, 0, 32'h8, 32'd3, 32'h0, 0), 1);
        applyStimulus(32'h00208463, 32'h100, 32'd5, 32'd5,
                      mkExp(6'h10, 32'd5, 32'd5, 5'd8, 0, 1, 0, 0, 0, 32'h104, 32'd5, 32'h108, 1), 1);
        @(posedge clock);
        #1;

        // JAL x1,+16 held for two cycles while ADD x5,x1,x2 waits
        out_ready = 1'b0;
        applyStimulus(32'h010000EF, 32'h200, 32'd0, 32'd0,
                      mkExp(6'h18, 32'h210, 32'd0, 5'd1, 1, 0, 0, 0, 0, 32'h204, 32'd0, 32'h0, 0), 1);
        in_instr = 32'h002082B3; in_pc = 32'h204; rs1_data = 32'd10; rs2_data = 32'd20; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checkOutput("stall in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall ALU_Control", 32'(ALU_Control), 32'h18);
            checkOutput("stall operand_A", operand_A, 32'h210);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(32'h002082B3, 32'h204, 32'd10, 32'd20,
                      mkExp(6'h00, 32'd10, 32'd20, 5'd5, 1, 0, 0, 0, 0, 32'h208, 32'd20, 32'h0, 0), 1);

        // Illegal all-zero word traps; an offered ADDI x2,x0,9 waits until trap_clear
        applyStimulus(32'h00000000, 32'h300, 32'd0, 32'd0,
                      mkExp(6'h00, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 1, 32'h304, 32'd0, 32'h0, 0), 1);
        in_instr = 32'h00900113; in_pc = 32'h304; rs1_data = 32'd0; rs2_data = 32'd0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checkOutput("trap in_ready", 32'(in_ready), 32'd0);
            checkOutput("trap_pending", 32'(trap_pending), 32'd1);
            @(posedge clock);
            #1;
        end
        trap_clear = 1'b1;
        @(negedge clock);
        checkOutput("trap_clear cycle in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1 trap_clear = 1'b0;
        @(negedge clock);
        checkOutput("after trap_clear in_ready", 32'(in_ready), 32'd1);
        checkOutput("after trap_clear trap_pending", 32'(trap_pending), 32'd0);
        if (in_ready)
            scoreboard.push_back(mkExp(6'h00, 32'd0, 32'd9, 5'd2, 1, 0, 0, 0, 0, 32'h308, 32'd0, 32'h0, 0));
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(posedge clock);
        #1;

        // OR x6,x1,x2 held, then flushed together with an offered XOR; neither must issue
        out_ready = 1'b0;
        applyStimulus(32'h0020E333, 32'h500, 32'hF0, 32'h0F, mkExp(6'h06, 32'hF0, 32'h0F, 5'd6, 1, 0, 0, 0, 0,
                      32'h504, 32'h0F, 32'h0, 0), 0);
        in_instr = 32'h0020C3B3; in_pc = 32'h504; in_valid = 1'b1; flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        checkOutput("flush held out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1 out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        checkOutput("flush incoming out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;

        // LW x8,12(x1) / SW x2,4(x1) / SRAI x9,x1,3 / ADD x0,x1,x2
        applyStimulus(32'h00C0A403, 32'h400, 32'h1000, 32'd0,
                      mkExp(6'h00, 32'h1000, 32'd12, 5'd8, 1, 0, 1, 0, 0, 32'h404, 32'd0, 32'h0, 0), 1);
        applyStimulus(32'h0020A223, 32'h404, 32'h1000, 32'hDEAD,
                      mkExp(6'h00, 32'h1000, 32'd4, 5'd4, 0, 0, 0, 1, 0, 32'h408, 32'hDEAD, 32'h0, 0), 1);
        applyStimulus(32'h4030D493, 32'h408, 32'h80000000, 32'd0,
                      mkExp(6'h0D, 32'h80000000, 32'd3, 5'd9, 1, 0, 0, 0, 0, 32'h40C, 32'd0, 32'h0, 0), 1);
        applyStimulus(32'h00208033, 32'h40C, 32'd1, 32'd2,
                      mkExp(6'h00, 32'd1, 32'd2, 5'd0, 0, 0, 0, 0, 0, 32'h410, 32'd2, 32'h0, 0), 1);
        @(posedge clock);
        #1;

        // Reset while an op is stalled loses it
        out_ready = 1'b0;
        applyStimulus(32'h00500093, 32'h600, 32'd0, 32'd0,
                      mkExp(6'h00, 32'd0, 32'd5, 5'd1, 1, 0, 0, 0, 0, 32'h604, 32'd0, 32'h0, 0), 0);
        @(negedge clock);
        checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid-stall reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid-stall reset rd_write", 32'(rd_write), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1; out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
